gcd_job_sequencer: RTL

- Upstream/downstream wrapper for the subtractive GCD core. Accepts operand pairs over a valid/ready input channel and drives the core's serial load protocol: clear, A on data bus with start, then B.
- Waits for the core's done, captures the result, and returns it over a valid/ready output channel.
- Guards the core against zero operands, which never terminate in a subtractive loop, and against hangs, using a watchdog.

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_watchdog.sv | 32 +++
 rtl/gcd_job_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job sequencer: FSM state encoding and
// default sizing.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD_A,
        LOAD_B,
        RUN,
        RESP
    } state_t;

    localparam int GCD_WIDTH       = 16;
    localparam int GCD_CYCLE_LIMIT = 65600;

endpackage

// File: rtl/gcd_watchdog.sv
// RUN-phase cycle counter; expired flags the final permitted RUN cycle.
module gcd_watchdog
    import gcd_pkg::*;
#(
    parameter int CYCLE_LIMIT = GCD_CYCLE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(CYCLE_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLE_LIMIT - 1);

    logic [CW-1:0] r_count;

    // Saturates at LAST so a missed exit can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/gcd_job_sequencer.sv
// Wraps the subtractive GCD core: accepts operand pairs, drives the core's
// clear/start/data load sequence, and returns the result or a timeout.
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH       = GCD_WIDTH,
    parameter int CYCLE_LIMIT = GCD_CYCLE_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             core_clr,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result
);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out_gcd;
    logic             r_out_err;
    logic             r_core_clr;
    logic             r_core_start;
    logic [WIDTH-1:0] r_core_data;

    logic w_wd_clr;
    logic w_wd_en;
    logic w_wd_expired;

    assign w_wd_clr = (r_state == LOAD_B);
    assign w_wd_en  = (r_state == RUN);

    gcd_watchdog #(
        .CYCLE_LIMIT (CYCLE_LIMIT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_expired (w_wd_expired)
    );

    // Outputs are set on the edge entering a state so they are valid for
    // exactly the cycle that state occupies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_out_gcd    <= '0;
            r_out_err    <= 1'b0;
            r_core_clr   <= 1'b0;
            r_core_start <= 1'b0;
            r_core_data  <= '0;
        end else begin
            r_core_clr   <= 1'b0;
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a <= in_a;
                        r_b <= in_b;
                        // A zero operand would never terminate in the core.
                        if ((in_a == '0) || (in_b == '0)) begin
                            r_out_gcd <= in_a | in_b;
                            r_out_err <= 1'b0;
                            r_state   <= RESP;
                        end else begin
                            r_core_clr <= 1'b1;
                            r_state    <= CLR;
                        end
                    end
                end
                CLR: begin
                    r_core_data  <= r_a;
                    r_core_start <= 1'b1;
                    r_state      <= LOAD_A;
                end
                LOAD_A: begin
                    r_core_data <= r_b;
                    r_state     <= LOAD_B;
                end
                LOAD_B: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (core_done) begin
                        r_out_gcd <= core_result;
                        r_out_err <= 1'b0;
                        r_state   <= RESP;
                    end else if (w_wd_expired) begin
                        r_out_gcd <= '0;
                        r_out_err <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == RESP);
    assign out_gcd    = r_out_gcd;
    assign out_err    = r_out_err;
    assign core_clr   = r_core_clr;
    assign core_start = r_core_start;
    assign core_data  = r_core_data;

endmodule
